// File: rtl/ppm8_rx_sequencer.sv
// 8-slot PPM receive sequencer: bins SPAD pulses per chip, hands each frame to the correlator, and registers the result.
// Optional statistics counters are built when PPM8_SEQ_STATS_EN is defined.
module ppm8_rx_sequencer #(
    parameter int CHIP_BITS   = 4,
    parameter int CHIP_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   resync,
    input  logic                   spad_in,
    input  logic [CHIP_BITS-1:0]   cfg_threshold,
    output logic [8*CHIP_BITS-1:0] corr_chips,
    output logic                   corr_input_valid,
    output logic [CHIP_BITS-1:0]   corr_threshold,
    input  logic [2:0]             corr_symbol,
    input  logic [CHIP_BITS-1:0]   corr_peak,
    input  logic                   corr_threshold_unmet,
    output logic [2:0]             sym_data,
    output logic [CHIP_BITS-1:0]   sym_peak,
    output logic                   sym_erasure,
    output logic                   sym_valid,
    input  logic                   sym_ready,
`ifdef PPM8_SEQ_STATS_EN
    output logic [15:0]            stat_symbols,
    output logic [15:0]            stat_erasures,
`endif
    output logic                   overflow
);

    localparam int CYC_W = (CHIP_CYCLES > 2) ? $clog2(CHIP_CYCLES) : 1;
    localparam logic [CHIP_BITS-1:0] BIN_MAX = '1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(CHIP_CYCLES - 1);

    typedef enum logic {IDLE, ACQ} state_t;

    state_t               state_reg, state_next;
    logic [2:0]           chip_reg, chip_next;
    logic [CYC_W-1:0]     cyc_reg, cyc_next;
    logic [CHIP_BITS-1:0] bin_reg [8];
    logic [CHIP_BITS-1:0] bin_next [8];
    logic [CHIP_BITS-1:0] bin_sampled [8];
    logic [CHIP_BITS-1:0] hold_reg [8];
    logic [CHIP_BITS-1:0] hold_next [8];
    logic [CHIP_BITS-1:0] thr_reg, thr_next;
    logic                 eval_reg, eval_next;
    logic [2:0]           sym_data_reg, sym_data_next;
    logic [CHIP_BITS-1:0] sym_peak_reg, sym_peak_next;
    logic                 sym_erasure_reg, sym_erasure_next;
    logic                 sym_valid_reg, sym_valid_next;
    logic                 overflow_reg, overflow_next;
    logic                 sym_end;

    // Per-chip saturating increment for the current sample; only the active chip moves.
    for (genvar gi = 0; gi < 8; gi++) begin : g_bin
        assign bin_sampled[gi] = (spad_in && chip_reg == 3'(gi) && bin_reg[gi] != BIN_MAX)
                               ? bin_reg[gi] + CHIP_BITS'(1) : bin_reg[gi];
        assign corr_chips[gi*CHIP_BITS +: CHIP_BITS] = hold_reg[gi];
    end

    assign sym_end = (chip_reg == 3'd7) && (cyc_reg == CYC_LAST);

    always_comb begin
        state_next = state_reg;
        chip_next  = chip_reg;
        cyc_next   = cyc_reg;
        bin_next   = bin_reg;
        hold_next  = hold_reg;
        thr_next   = thr_reg;
        eval_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                chip_next = '0;
                cyc_next  = '0;
                for (int k = 0; k < 8; k++) bin_next[k] = '0;
                if (en) state_next = ACQ;
            end
            ACQ: begin
                if (!en || sym_end || resync) begin
                    chip_next = '0;
                    cyc_next  = '0;
                    for (int k = 0; k < 8; k++) bin_next[k] = '0;
                    if (!en) begin
                        state_next = IDLE;
                    end else if (sym_end) begin
                        // Symbol end wins over resync so the completed frame is not lost.
                        hold_next = bin_sampled;
                        thr_next  = cfg_threshold;
                        eval_next = 1'b1;
                    end
                end else begin
                    bin_next = bin_sampled;
                    if (cyc_reg == CYC_LAST) begin
                        cyc_next  = '0;
                        chip_next = chip_reg + 3'd1;
                    end else begin
                        cyc_next = cyc_reg + CYC_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sym_data_next    = sym_data_reg;
        sym_peak_next    = sym_peak_reg;
        sym_erasure_next = sym_erasure_reg;
        sym_valid_next   = sym_valid_reg;
        overflow_next    = overflow_reg;
        if (eval_reg) begin
            if (sym_valid_reg && !sym_ready) begin
                overflow_next = 1'b1;
            end else begin
                sym_data_next    = corr_symbol;
                sym_peak_next    = corr_peak;
                sym_erasure_next = corr_threshold_unmet;
                sym_valid_next   = 1'b1;
            end
        end else if (sym_valid_reg && sym_ready) begin
            sym_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            chip_reg        <= '0;
            cyc_reg         <= '0;
            for (int k = 0; k < 8; k++) begin
                bin_reg[k]  <= '0;
                hold_reg[k] <= '0;
            end
            thr_reg         <= '0;
            eval_reg        <= 1'b0;
            sym_data_reg    <= '0;
            sym_peak_reg    <= '0;
            sym_erasure_reg <= 1'b0;
            sym_valid_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            chip_reg        <= chip_next;
            cyc_reg         <= cyc_next;
            bin_reg         <= bin_next;
            hold_reg        <= hold_next;
            thr_reg         <= thr_next;
            eval_reg        <= eval_next;
            sym_data_reg    <= sym_data_next;
            sym_peak_reg    <= sym_peak_next;
            sym_erasure_reg <= sym_erasure_next;
            sym_valid_reg   <= sym_valid_next;
            overflow_reg    <= overflow_next;
        end
    end

`ifdef PPM8_SEQ_STATS_EN
    logic [15:0] stat_symbols_reg, stat_erasures_reg;

    // Counts every correlator result, including ones dropped by backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_symbols_reg  <= '0;
            stat_erasures_reg <= '0;
        end else if (eval_reg) begin
            if (stat_symbols_reg != 16'hFFFF)
                stat_symbols_reg <= stat_symbols_reg + 16'd1;
            if (corr_threshold_unmet && stat_erasures_reg != 16'hFFFF)
                stat_erasures_reg <= stat_erasures_reg + 16'd1;
        end
    end

    assign stat_symbols  = stat_symbols_reg;
    assign stat_erasures = stat_erasures_reg;
`endif

    assign corr_input_valid = eval_reg;
    assign corr_threshold   = thr_reg;
    assign sym_data         = sym_data_reg;
    assign sym_peak         = sym_peak_reg;
    assign sym_erasure      = sym_erasure_reg;
    assign sym_valid        = sym_valid_reg;
    assign overflow         = overflow_reg;

endmodule

// File: tb/tb_ppm8_rx_sequencer.sv
// Directed bench for ppm8_rx_sequencer (CHIP_BITS=2, CHIP_CYCLES=4) with a behavioural correlator.
module tb_ppm8_rx_sequencer;

    localparam int CB = 2;
    localparam int CC = 4;

    logic          clk = 1'b0;
    logic          rst, en, resync, spad_in, sym_ready;
    logic [CB-1:0] cfg_threshold;
    logic [8*CB-1:0] corr_chips;
    logic          corr_input_valid;
    logic [CB-1:0] corr_threshold;
    logic [2:0]    corr_symbol;
    logic [CB-1:0] corr_peak;
    logic          corr_threshold_unmet;
    logic [2:0]    sym_data;
    logic [CB-1:0] sym_peak;
    logic          sym_erasure, sym_valid, overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ppm8_rx_sequencer #(.CHIP_BITS(CB), .CHIP_CYCLES(CC)) dut (
        .clk(clk), .rst(rst), .en(en), .resync(resync), .spad_in(spad_in),
        .cfg_threshold(cfg_threshold), .corr_chips(corr_chips),
        .corr_input_valid(corr_input_valid), .corr_threshold(corr_threshold),
        .corr_symbol(corr_symbol), .corr_peak(corr_peak),
        .corr_threshold_unmet(corr_threshold_unmet), .sym_data(sym_data),
        .sym_peak(sym_peak), .sym_erasure(sym_erasure), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .overflow(overflow)
    );

    // Correlator: first maximum bin wins; erasure when the peak is below the threshold.
    always_comb begin
        corr_symbol = 3'd0;
        corr_peak   = corr_chips[CB-1:0];
        for (int k = 1; k < 8; k++) begin
            if (corr_chips[k*CB +: CB] > corr_peak) begin
                corr_peak   = corr_chips[k*CB +: CB];
                corr_symbol = 3'(k);
            end
        end
        corr_threshold_unmet = (corr_peak < corr_threshold);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feed(input logic [31:0] pat, input int first, input int last);
        for (int s = first; s <= last; s++) begin
            spad_in = pat[s];
            tick();
        end
        spad_in = 1'b0;
    endtask

    task automatic chk_sym(input string tag, input logic v, input logic [2:0] d,
                           input logic [CB-1:0] p, input logic e);
        chk({tag, "_valid"}, 32'(sym_valid), 32'(v));
        chk({tag, "_data"}, 32'(sym_data), 32'(d));
        chk({tag, "_peak"}, 32'(sym_peak), 32'(p));
        chk({tag, "_erasure"}, 32'(sym_erasure), 32'(e));
    endtask

    initial begin
        logic seen_eval;
        rst = 1'b1; en = 1'b0; resync = 1'b0; spad_in = 1'b0;
        sym_ready = 1'b1; cfg_threshold = '0;
        tick(); tick();
        chk("rst_cv", 32'(corr_input_valid), 32'd0);
        chk("rst_chips", 32'(corr_chips), 32'd0);
        chk("rst_thr", 32'(corr_threshold), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk_sym("rst", 1'b0, 3'd0, 2'd0, 1'b0);
        rst = 1'b0;
        tick();

        // Basic decode: 3 pulses in chip 5, 1 in chip 1
        cfg_threshold = 2'd2; en = 1'b1;
        tick();
        feed(32'h0070_0010, 0, 31);
        chk("t1_cv", 32'(corr_input_valid), 32'd1);
        chk("t1_chips", 32'(corr_chips), 32'h0C04);
        chk("t1_thr", 32'(corr_threshold), 32'd2);
        chk("t1_pre_valid", 32'(sym_valid), 32'd0);
        en = 1'b0;
        tick();
        chk("t1_cv_drop", 32'(corr_input_valid), 32'd0);
        chk_sym("t1", 1'b1, 3'd5, 2'd3, 1'b0);
        tick();
        chk("t1_xfer", 32'(sym_valid), 32'd0);

        // Erasure: empty frame
        cfg_threshold = 2'd1; en = 1'b1;
        tick();
        feed(32'h0, 0, 31);
        chk("t2_cv", 32'(corr_input_valid), 32'd1);
        chk("t2_chips", 32'(corr_chips), 32'h0);
        en = 1'b0;
        tick();
        chk_sym("t2", 1'b1, 3'd0, 2'd0, 1'b1);
        tick();

        // Saturation, then a gapless second symbol starting from clear bins
        en = 1'b1;
        tick();
        feed(32'h0000_0F00, 0, 31);
        chk("t3_chips_a", 32'(corr_chips), 32'h0030);
        tick();
        chk_sym("t3a", 1'b1, 3'd2, 2'd3, 1'b0);
        feed(32'h1000_0000, 1, 31);
        chk("t3_cv_b", 32'(corr_input_valid), 32'd1);
        chk("t3_chips_b", 32'(corr_chips), 32'h4000);
        en = 1'b0;
        tick();
        chk_sym("t3b", 1'b1, 3'd7, 2'd1, 1'b0);
        tick();

        // Backpressure across two symbols
        sym_ready = 1'b0; cfg_threshold = 2'd2; en = 1'b1;
        tick();
        feed(32'h0000_3000, 0, 31);
        tick();
        chk_sym("t4a", 1'b1, 3'd3, 2'd2, 1'b0);
        chk("t4_ovf0", 32'(overflow), 32'd0);
        feed(32'h0700_0000, 1, 31);
        chk("t4_cv_b", 32'(corr_input_valid), 32'd1);
        chk("t4_chips_b", 32'(corr_chips), 32'h3000);
        en = 1'b0;
        tick();
        chk_sym("t4hold", 1'b1, 3'd3, 2'd2, 1'b0);
        chk("t4_ovf1", 32'(overflow), 32'd1);
        sym_ready = 1'b1;
        tick();
        chk("t4_xfer", 32'(sym_valid), 32'd0);
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);
        tick();
        chk("t4_ovf_sticky2", 32'(overflow), 32'd1);

        // Resync in chip 3: chip-1 pulses discarded
        cfg_threshold = 2'd1; en = 1'b1;
        tick();
        feed(32'h0000_0030, 0, 11);
        resync = 1'b1;
        tick();
        resync = 1'b0;
        feed(32'h0100_0000, 0, 31);
        chk("t5_cv", 32'(corr_input_valid), 32'd1);
        chk("t5_chips", 32'(corr_chips), 32'h1000);
        chk("t5_pre_valid", 32'(sym_valid), 32'd0);
        en = 1'b0;
        tick();
        chk_sym("t5", 1'b1, 3'd6, 2'd1, 1'b0);
        tick();

        // Reset at chip 4 while holding a result
        sym_ready = 1'b0; cfg_threshold = 2'd2; en = 1'b1;
        tick();
        feed(32'h0000_0001, 0, 31);
        chk("t6_chips", 32'(corr_chips), 32'h0001);
        tick();
        chk_sym("t6a", 1'b1, 3'd0, 2'd1, 1'b1);
        feed(32'h0, 1, 16);
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;
        chk("t6_cv", 32'(corr_input_valid), 32'd0);
        chk("t6_chips0", 32'(corr_chips), 32'd0);
        chk("t6_thr", 32'(corr_threshold), 32'd0);
        chk("t6_ovf", 32'(overflow), 32'd0);
        chk_sym("t6rst", 1'b0, 3'd0, 2'd0, 1'b0);
        seen_eval = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (corr_input_valid) seen_eval = 1'b1;
        end
        chk("t6_no_eval", 32'(seen_eval), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppm8_rx_sequencer.md
Name: ppm8_rx_sequencer

Overview:
Front-end sequencer for the 8-slot PPM receive path. It bins single-bit SPAD pulses into eight chip slots over one symbol period, and hands each completed frame to the ppm8 correlator for one cycle. It then captures the returned symbol, peak and threshold flag into a valid/ready output register. It sits between the SPAD pulse conditioner and the symbol deframer, and owns symbol timing, resync and backpressure handling.

Parameters:
CHIP_BITS, 4, width of each chip bin count; must match the correlator CHIP_BITS.
CHIP_CYCLES, 16, clock cycles per chip slot (>=2); symbol period = 8*CHIP_CYCLES cycles.

Ports:
clk  input  1  single clock, all logic rising-edge.
rst  input  1  reset; synchronous, active-high.
en  input  1  acquisition enable.
resync  input  1  one-cycle pulse; restarts the symbol frame at chip 0.
spad_in  input  1  SPAD pulse, sampled every cycle.
cfg_threshold  input  CHIP_BITS  correlation threshold.
corr_chips  output  8*CHIP_BITS  bin bank to the correlator; chip k is at bits [k*CHIP_BITS +: CHIP_BITS].
corr_input_valid  output  1  correlator input_valid.
corr_threshold  output  CHIP_BITS  threshold to the correlator, latched per symbol.
corr_symbol  input  3  correlator symbol result.
corr_peak  input  CHIP_BITS  correlator peak_value.
corr_threshold_unmet  input  1  correlator threshold_unmet.
sym_data  output  3  decoded symbol.
sym_peak  output  CHIP_BITS  peak bin count.
sym_erasure  output  1  peak below threshold.
sym_valid  output  1  output register holds a result.
sym_ready  input  1  downstream accepts the result.
overflow  output  1  sticky: a result was dropped.

Behaviour:
- Reset: state IDLE; all bins, hold bank, chip/cycle counters, corr_threshold, sym_* and overflow = 0.
- FSM states:
  - IDLE: bins cleared, counters at 0. If en=1 in an IDLE cycle, the next cycle is the first sample cycle (chip 0, cyc 0) in ACQ.
  - ACQ: every cycle, if spad_in=1, bin[chip] increments and saturates at 2^CHIP_BITS-1. cyc counts 0..CHIP_CYCLES-1; chip increments when cyc wraps.
  - Symbol end (chip=7, cyc=CHIP_CYCLES-1): that cycle's sample is included. Bins then move to the hold bank, cfg_threshold moves to corr_threshold, bins clear, and the next cycle is chip 0, cyc 0. Integration is gapless.
- EVAL runs in parallel with ACQ, in the cycle after symbol end:
  - corr_input_valid=1 for exactly that one cycle; corr_chips = hold bank, which stays stable until the next transfer.
  - corr_input_valid=0 otherwise.
  - At the end of the EVAL cycle, the result is captured: sym_data=corr_symbol, sym_peak=corr_peak, sym_erasure=corr_threshold_unmet, sym_valid=1.
  - Latency: sym_valid rises 2 cycles after the last sample cycle of the symbol.
- Handshake:
  - A transfer occurs when sym_valid&sym_ready; sym_valid clears next cycle unless a new capture happens in the same cycle.
  - sym_* are held stable while sym_valid=1 and sym_ready=0.
  - If a capture occurs when sym_valid=1 and sym_ready=0, the new result is dropped, the old one is kept, and overflow is set. overflow clears only on rst.
  - Capture in the same cycle as a transfer loads the new result; this is not an overflow.
- en deasserted in ACQ: go to IDLE next cycle and discard the partial symbol. A pending EVAL still completes, and the output register keeps its contents.
- resync in ACQ: the next cycle is chip 0, cyc 0, with bins cleared and the partial symbol discarded.
  - resync on a symbol-end cycle: the transfer still happens first.
  - resync in IDLE is ignored. en=0 takes priority over resync.
- rst mid-operation: everything returns to reset values next cycle; a pending EVAL is cancelled.

Optional Feature:
PPM8_SEQ_STATS_EN:
- Defined: adds outputs stat_symbols[15:0] and stat_erasures[15:0]. They count captured results (including dropped ones) and captured results with erasure=1, saturate at 16'hFFFF, and clear on rst.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
(All with CHIP_BITS=2, CHIP_CYCLES=4, behavioural correlator model.)
1. Basic decode: en at cycle 0, cfg_threshold=2, spad_in=1 for 3 cycles of chip 5 and 1 cycle of chip 1, sym_ready=1 -> corr_input_valid at cycle 33; cycle 34: sym_valid=1, sym_data=5, sym_peak=3, sym_erasure=0.
2. Erasure: no pulses, cfg_threshold=1 -> sym_data=0, sym_peak=0, sym_erasure=1.
3. Saturation: spad_in=1 for all 4 cycles of chip 2 -> sym_peak=3 (not 0), sym_data=2; the next symbol's bins start from 0.
4. Backpressure: sym_ready=0 across two symbols -> first result held unchanged, second dropped, overflow=1. Raise sym_ready -> one transfer; overflow stays 1 until rst.
5. Resync: resync at chip 3 of a frame with pulses in chip 1 and chip 6 (after resync) -> chip-1 pulses ignored; sym_valid rises 34 cycles after the resync cycle with sym_data=6.
6. Reset mid-symbol: rst at chip 4 with sym_valid=1 -> next cycle all outputs 0, overflow 0, state IDLE; no corr_input_valid afterwards until en.
